instr_encode: RTL

- Streaming RV32I instruction encoder; the inverse of the decode stage. Accepts decoded fields (opcode, rd, funct3, rs1, rs2, funct7, imm) over a valid/ready handshake and emits packed 32-bit instruction words with byte addresses.
- Used by the test program loader and the self-check harness to fill instruction memory.
- Covers the same instruction set the decoder supports: R-type, load, I-type ALU, store, LUI.
- Contains an illegal-field checker and a program-sequencing FSM.

---
 rtl/instr_encode.sv | 108 ++++++++++
 1 files changed

// File: rtl/instr_encode.sv
// instr_encode: streams decoded RV32I fields into packed instruction words with byte addresses
//   start/in_* : program start pulse and field beats (valid/ready, last marker)
//   out_*      : registered instruction word, address, illegal flag, last marker (valid/ready)
//   busy/done/err_cnt : sequencing status and saturating illegal-beat count
module instr_encode #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int ADDR_WIDTH = 32,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_last,
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  input  logic [2:0] funct3,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [6:0] funct7,
  input  logic [31:0] imm,
  output logic out_valid,
  input  logic out_ready,
  output logic [31:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic out_err,
  output logic out_last,
  output logic busy,
  output logic done,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [31:0] word;
  logic legal, imm_ok, mem_ok, hi_zero, accept, restart;
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign restart = start && (state == IDLE || state == FIN);
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = state == FIN;
  always_comb begin
    imm_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
    mem_ok = (funct3 == 3'b000) || (funct3 == 3'b010);
    hi_zero = imm[31:12] == '0;
    legal = 1'b0;
    word = {imm[11:0], rs1, funct3, rd, opcode};
    case (opcode)
      7'b0110011: begin
        legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      7'b0000011: legal = mem_ok && imm_ok;
      // shifts carry shamt in imm[4:0]; imm[11:5] selects logical/arithmetic, arithmetic only for right
      7'b0010011: legal = (funct3 == 3'b001) ? hi_zero && (imm[11:5] == 7'b0000000) :
                          (funct3 == 3'b101) ? hi_zero && ((imm[11:5] == 7'b0000000) || (imm[11:5] == 7'b0100000)) :
                          imm_ok;
      7'b0100011: begin
        legal = mem_ok && imm_ok;
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      7'b0110111: begin
        legal = imm[11:0] == '0;
        word = {imm[31:12], rd, opcode};
      end
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? RUN : IDLE;
      RUN: state_n = (accept && in_last) ? DRAIN : RUN;
      DRAIN: state_n = (out_valid && out_ready && out_last) ? FIN : DRAIN;
      default: state_n = start ? RUN : FIN;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err <= 1'b0;
      out_last <= 1'b0;
      out_addr <= BASE;
      next_addr <= BASE;
      err_cnt <= '0;
    end else begin
      if (restart) begin
        next_addr <= BASE;
        err_cnt <= '0;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_instr <= legal ? word : NOP;
        out_err <= !legal;
        out_last <= in_last;
        out_addr <= next_addr;
        next_addr <= next_addr + ADDR_WIDTH'(4);
        if (!legal && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
endmodule
